// File: rtl/ccr_controller.sv
// Condition-code register beside the ALU, with interrupt entry/return sequencing.
// Holds one frozen CCR copy across an ISR and restores it on RTI.
module ccr_controller #(
  parameter int unsigned ENTRY_CYCLES = 2,
  parameter logic [4:0]  ALU_RTI      = 5'b10100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] aluSignals,
  input  logic       ccrWriteEn,
  input  logic       zeroFlagIn,
  input  logic       carryFlagIn,
  input  logic       overFlowFlagIn,
  input  logic       negativeFlagIn,
  input  logic       interrupt,
  output logic       zeroFlag,
  output logic       carryFlag,
  output logic       overFlowFlag,
  output logic       negativeFlag,
  output logic [3:0] freezedCCR,
  output logic       stall,
  output logic       intEntry,
  output logic [1:0] entryIndex,
  output logic       inIsr,
  output logic       intPending
);

  typedef enum logic [1:0] {StRun, StEnter, StIsr} state_e;

  localparam logic [1:0] LastIdx = 2'(ENTRY_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] ccr_q, ccr_d;
  logic [3:0] frz_q, frz_d;
  logic [1:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  logic [3:0] alu_flags;
  logic       is_rti;

  assign alu_flags = {negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn};
  assign is_rti    = (aluSignals == ALU_RTI);

  always_comb begin
    state_d = state_q;
    ccr_d   = ccr_q;
    frz_d   = frz_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRun: begin
        if (ccrWriteEn && !is_rti) ccr_d = alu_flags;
        // The snapshot includes any commit landing on the same edge.
        if (interrupt || pend_q) begin
          frz_d   = ccr_d;
          state_d = StEnter;
          idx_d   = 2'd0;
          pend_d  = 1'b0;
        end
      end
      StEnter: begin
        if (interrupt) pend_d = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIsr;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StIsr: begin
        if (interrupt) pend_d = 1'b1;
        if (ccrWriteEn) begin
          if (is_rti) begin
            ccr_d   = frz_q;
            state_d = StRun;
          end else begin
            ccr_d = alu_flags;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      ccr_q   <= 4'b0000;
      frz_q   <= 4'b0000;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ccr_q   <= ccr_d;
      frz_q   <= frz_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  assign {negativeFlag, overFlowFlag, carryFlag, zeroFlag} = ccr_q;
  assign freezedCCR = frz_q;
  assign stall      = (state_q == StEnter);
  assign intEntry   = (state_q == StEnter);
  assign inIsr      = (state_q == StIsr);
  assign entryIndex = idx_q;
  assign intPending = pend_q;

endmodule

// File: tb/tb_ccr_controller.sv
// Scoreboard bench for ccr_controller: expected output words are queued as stimulus is
// driven and popped one cycle later when the registered outputs are sampled.
module tb_ccr_controller;

  localparam logic [4:0] Rti = 5'b10100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] aluSignals = 5'd0;
  logic       ccrWriteEn = 1'b0;
  logic       zeroFlagIn = 1'b0, carryFlagIn = 1'b0, overFlowFlagIn = 1'b0;
  logic       negativeFlagIn = 1'b0;
  logic       interrupt = 1'b0;
  logic       zeroFlag, carryFlag, overFlowFlag, negativeFlag;
  logic [3:0] freezedCCR;
  logic       stall, intEntry, inIsr, intPending;
  logic [1:0] entryIndex;

  int checks = 0;
  int errors = 0;
  logic [13:0] sb[$];

  ccr_controller #(.ENTRY_CYCLES(2), .ALU_RTI(Rti)) dut (
    .clk(clk), .rst(rst), .aluSignals(aluSignals), .ccrWriteEn(ccrWriteEn),
    .zeroFlagIn(zeroFlagIn), .carryFlagIn(carryFlagIn), .overFlowFlagIn(overFlowFlagIn),
    .negativeFlagIn(negativeFlagIn), .interrupt(interrupt),
    .zeroFlag(zeroFlag), .carryFlag(carryFlag), .overFlowFlag(overFlowFlag),
    .negativeFlag(negativeFlag), .freezedCCR(freezedCCR), .stall(stall),
    .intEntry(intEntry), .entryIndex(entryIndex), .inIsr(inIsr), .intPending(intPending)
  );

  always #5 clk = ~clk;

  // Output word: {N,O,C,Z, freezedCCR, stall, intEntry, entryIndex, inIsr, intPending}
  function automatic logic [13:0] outs();
    return {negativeFlag, overFlowFlag, carryFlag, zeroFlag, freezedCCR, stall, intEntry,
            entryIndex, inIsr, intPending};
  endfunction

  function automatic logic [13:0] e(logic [3:0] ccr, logic [3:0] frz, logic st,
                                    logic [1:0] idx, logic isr, logic pend);
    return {ccr, frz, st, st, idx, isr, pend};
  endfunction

  // Stimulus word: {interrupt, ccrWriteEn, rti, N, O, C, Z}
  task automatic drive(input logic [6:0] s);
    interrupt  = s[6];
    ccrWriteEn = s[5];
    aluSignals = s[4] ? Rti : 5'd0;
    {negativeFlagIn, overFlowFlagIn, carryFlagIn, zeroFlagIn} = s[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got, want;
    rst = 1'b0;
    drive(7'b0);
    step();
    step();
    sb.push_back(14'd0);
    got = outs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_init got %b expected %b", got, want);
    end
    #3 rst = 1'b1;
    step();
    drive(7'b1_1_0_1111);
    step();
    sb.push_back(e(4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b0));
    got = outs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_pre_enter got %b expected %b", got, want);
    end
    drive(7'b0);
    #2 rst = 1'b0;
    #1;
    sb.push_back(14'd0);
    got = outs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_async_mid_enter got %b expected %b", got, want);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_commit();
    logic [6:0]  st[0:1];
    logic [13:0] ex[0:1];
    logic [13:0] got, want;
    st = '{7'b0_1_0_1010, 7'b0_0_0_0101};
    ex = '{e(4'b1010, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0), e(4'b1010, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL commit[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_interrupt_entry();
    logic [6:0]  st[0:1];
    logic [13:0] ex[0:1];
    logic [13:0] got, want;
    st = '{7'b0_1_0_0110, 7'b1_1_0_1001};
    ex = '{e(4'b0110, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0),
           e(4'b1001, 4'b1001, 1'b1, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL int_entry[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_stall_blocks();
    logic [6:0]  st[0:1];
    logic [13:0] ex[0:1];
    logic [13:0] got, want;
    st = '{7'b0_1_0_1111, 7'b0_1_0_1111};
    ex = '{e(4'b1001, 4'b1001, 1'b1, 2'd1, 1'b0, 1'b0),
           e(4'b1001, 4'b1001, 1'b0, 2'd0, 1'b1, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL stall_blocks[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_rti();
    logic [6:0]  st[0:1];
    logic [13:0] ex[0:1];
    logic [13:0] got, want;
    st = '{7'b0_1_0_0001, 7'b0_1_1_1111};
    ex = '{e(4'b0001, 4'b1001, 1'b0, 2'd0, 1'b1, 1'b0),
           e(4'b1001, 4'b1001, 1'b0, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL rti[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  st[0:14];
    logic [13:0] ex[0:14];
    logic [13:0] got, want;
    st = '{7'b0_1_0_0011, 7'b1_0_0_0000, 7'b0_0_0_0000, 7'b0_0_0_0000, 7'b0_1_0_1100,
           7'b1_1_1_0000, 7'b0_0_0_0000, 7'b1_0_0_0000, 7'b0_0_0_0000, 7'b1_1_0_1000,
           7'b0_1_1_1111, 7'b0_1_0_0110, 7'b0_0_0_0000, 7'b0_1_1_1111, 7'b0_1_1_0000};
    ex = '{e(4'b0011, 4'b1001, 1'b0, 2'd0, 1'b0, 1'b0),
           e(4'b0011, 4'b0011, 1'b1, 2'd0, 1'b0, 1'b0),
           e(4'b0011, 4'b0011, 1'b1, 2'd1, 1'b0, 1'b0),
           e(4'b0011, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0),
           e(4'b1100, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0),
           e(4'b0011, 4'b0011, 1'b0, 2'd0, 1'b0, 1'b1),
           e(4'b0011, 4'b0011, 1'b1, 2'd0, 1'b0, 1'b0),
           e(4'b0011, 4'b0011, 1'b1, 2'd1, 1'b0, 1'b1),
           e(4'b0011, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b1),
           e(4'b1000, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b1),
           e(4'b0011, 4'b0011, 1'b0, 2'd0, 1'b0, 1'b1),
           e(4'b0110, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0),
           e(4'b0110, 4'b0110, 1'b1, 2'd1, 1'b0, 1'b0),
           e(4'b0110, 4'b0110, 1'b0, 2'd0, 1'b1, 1'b0),
           e(4'b0110, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 15; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL back_to_back[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_spurious_rti();
    logic [6:0]  st[0:2];
    logic [13:0] ex[0:2];
    logic [13:0] got, want;
    st = '{7'b0_1_0_0100, 7'b0_1_1_1111, 7'b0_0_0_0000};
    ex = '{e(4'b0100, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0),
           e(4'b0100, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0),
           e(4'b0100, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); step();
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL spurious_rti[%0d] got %b expected %b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_interrupt_entry();
    test_stall_blocks();
    test_rti();
    test_back_to_back();
    test_spurious_rti();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
